pwm_burst_ctrl: RTL

PWM_BURST_CTRL -- requirements
Module: pwm_burst_ctrl

---
 rtl/pwm_burst_ctrl_if.sv | 39 +++
 rtl/pwm_burst_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pwm_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_burst_ctrl_if
// Desc     : Configuration bus for pwm_burst_ctrl (write strobe, fields, error).
//            PWM_PHASE_EN adds the cfg_phase field.
// Revision : 1.0 - initial release
// ============================================================================
interface pwm_burst_ctrl_if #(
    parameter int CNT_W   = 16,
    parameter int PULSE_W = 8
);
    logic               cfg_wr;
    logic [7:0]         cfg_ch;
    logic [CNT_W-1:0]   cfg_period;
    logic [CNT_W-1:0]   cfg_high;
    logic [PULSE_W-1:0] cfg_pulses;
    logic               cfg_start;
`ifdef PWM_PHASE_EN
    logic [CNT_W-1:0]   cfg_phase;
`endif
    logic               cfg_err;

    modport master (
        output cfg_wr, cfg_ch, cfg_period, cfg_high, cfg_pulses, cfg_start,
`ifdef PWM_PHASE_EN
        output cfg_phase,
`endif
        input  cfg_err
    );

    modport slave (
        input  cfg_wr, cfg_ch, cfg_period, cfg_high, cfg_pulses, cfg_start,
`ifdef PWM_PHASE_EN
        input  cfg_phase,
`endif
        output cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/pwm_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_burst_ctrl
// Desc     : NUM_CH independent PWM burst channels with shadowed configuration.
//            Define PWM_PHASE_EN to add a per-start phase delay (cfg_phase).
// Revision : 1.0 - initial release
// ============================================================================
module pwm_burst_ctrl #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int PULSE_W = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    pwm_burst_ctrl_if.slave     cfg,
    input  logic [NUM_CH-1:0]   abort,
    output logic [NUM_CH-1:0]   pwm_out,
    output logic [NUM_CH-1:0]   pwm_busy,
    output logic [NUM_CH-1:0]   pwm_done
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic w_ch_ok;
    logic w_sel_busy;
    logic w_wr_ok;
    logic r_err;

    assign w_ch_ok = int'(cfg.cfg_ch) < NUM_CH;

    always_comb begin
        w_sel_busy = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cfg.cfg_ch == 8'(k)) w_sel_busy = pwm_busy[k];
        end
    end

    // A rejected write must not touch any channel, so every channel sees only w_wr_ok.
    assign w_wr_ok = cfg.cfg_wr && w_ch_ok && (cfg.cfg_period != '0) &&
                     !(cfg.cfg_start && w_sel_busy);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_err <= 1'b0;
        else            r_err <= cfg.cfg_wr && !w_wr_ok;
    end

    assign cfg.cfg_err = r_err;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [7:0] c_IDX = 8'(i);

        logic [1:0]         r_state;
        logic [CNT_W-1:0]   r_cnt, r_per, r_high, r_sh_per, r_sh_high;
        logic [PULSE_W-1:0] r_pcnt, r_pls, r_sh_pls;
        logic               r_pwm, r_busy, r_done;
`ifdef PWM_PHASE_EN
        localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);
        logic [CNT_W-1:0]   r_ph_cnt;
`endif

        logic               w_hit, w_wrap, w_last;
        logic [CNT_W-1:0]   w_cnt_inc, w_nx_per, w_nx_high;
        logic [PULSE_W-1:0] w_pcnt_inc, w_nx_pls;

        assign w_hit      = w_wr_ok && (cfg.cfg_ch == c_IDX);
        assign w_cnt_inc  = r_cnt + 1'b1;
        assign w_wrap     = (w_cnt_inc == r_per);
        assign w_pcnt_inc = (r_pls == '0) ? '0 :
                            ((&r_pcnt) ? r_pcnt : r_pcnt + 1'b1);
        assign w_last     = (r_pls != '0) && (w_pcnt_inc >= r_pls);
        // A write landing on the wrap cycle takes effect immediately rather than a period late.
        assign w_nx_per   = w_hit ? cfg.cfg_period : r_sh_per;
        assign w_nx_high  = w_hit ? cfg.cfg_high   : r_sh_high;
        assign w_nx_pls   = w_hit ? cfg.cfg_pulses : r_sh_pls;

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                r_state   <= c_IDLE;
                r_cnt     <= '0;
                r_pcnt    <= '0;
                r_per     <= '0;
                r_high    <= '0;
                r_pls     <= '0;
                r_sh_per  <= '0;
                r_sh_high <= '0;
                r_sh_pls  <= '0;
                r_pwm     <= 1'b0;
                r_busy    <= 1'b0;
                r_done    <= 1'b0;
`ifdef PWM_PHASE_EN
                r_ph_cnt  <= '0;
`endif
            end else begin
                r_done <= 1'b0;
                if (w_hit) begin
                    r_sh_per  <= cfg.cfg_period;
                    r_sh_high <= cfg.cfg_high;
                    r_sh_pls  <= cfg.cfg_pulses;
                end
                case (r_state)
                    c_RUN: begin
                        if (abort[i] || (w_wrap && w_last)) begin
                            r_state <= c_DONE;
                            r_pwm   <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
`ifdef PWM_PHASE_EN
                        else if (r_ph_cnt != '0) begin
                            r_ph_cnt <= r_ph_cnt - 1'b1;
                            r_pwm    <= (r_ph_cnt == c_ONE) && (r_high != '0);
                        end
`endif
                        else if (w_wrap) begin
                            r_cnt  <= '0;
                            r_pcnt <= w_pcnt_inc;
                            r_per  <= w_nx_per;
                            r_high <= w_nx_high;
                            r_pls  <= w_nx_pls;
                            r_pwm  <= (w_nx_high != '0);
                        end else begin
                            r_cnt <= w_cnt_inc;
                            r_pwm <= (w_cnt_inc < r_high);
                        end
                    end
                    default: begin
                        r_state <= c_IDLE;
                        r_pwm   <= 1'b0;
                        r_busy  <= 1'b0;
                        if (w_hit && cfg.cfg_start) begin
                            r_state <= c_RUN;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                            r_pcnt  <= '0;
                            r_per   <= cfg.cfg_period;
                            r_high  <= cfg.cfg_high;
                            r_pls   <= cfg.cfg_pulses;
`ifdef PWM_PHASE_EN
                            r_ph_cnt <= cfg.cfg_phase;
                            r_pwm    <= (cfg.cfg_phase == '0) && (cfg.cfg_high != '0);
`else
                            r_pwm    <= (cfg.cfg_high != '0);
`endif
                        end
                    end
                endcase
            end
        end

        assign pwm_out[i]  = r_pwm;
        assign pwm_busy[i] = r_busy;
        assign pwm_done[i] = r_done;
    end

endmodule
`default_nettype wire
